// File: rtl/aes128_iter_core.sv
// aes128_iter_core: iterative AES-128 encryptor with valid/ready handshakes.
// ROUNDS_PER_CYCLE rounds are unrolled per clock. The round key is expanded
// on the fly alongside the data path, so no key schedule is stored.
module aes128_iter_core #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int NCYC = (ROUNDS_PER_CYCLE > 0) ? (10 / ROUNDS_PER_CYCLE) : 0;
  localparam logic [3:0] C_STEP = 4'(ROUNDS_PER_CYCLE);
  localparam logic [3:0] C_LAST = 4'd10;

  // Only unroll factors that divide the 10 rounds evenly are supported.
  if ((ROUNDS_PER_CYCLE < 1) || ((ROUNDS_PER_CYCLE * NCYC) != 10)) begin : g_bad_rounds
    $error("aes128_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
  end

  // Forward S-box, byte 0x00 in the top byte of the vector.
  localparam logic [2047:0] C_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Byte substitution; entry b sits at bit {~b,3'b111} downward.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return C_SBOX[{~b, 3'b111} -: 8];
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Round constant for round r (1..10).
  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // Derive K_r from K_(r-1): RotWord, SubWord, Rcon, then the xor ripple.
  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h000000};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // One AES round; byte k of the block is element 15-k of the packed array,
  // and state[row][col] is byte row+4*col.
  function automatic logic [127:0] aes_round(input logic [127:0] s_in, input logic [127:0] rk,
                                             input logic last);
    logic [15:0][7:0] s;
    logic [15:0][7:0] t;
    logic [15:0][7:0] m;
    logic [7:0] a0, a1, a2, a3;
    s = s_in;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        t[4'(15 - (r + 4 * c))] = sbox(s[4'(15 - (r + 4 * ((c + r) % 4)))]);
      end
    end
    for (int c = 0; c < 4; c++) begin
      a0 = t[4'(15 - 4 * c)];
      a1 = t[4'(14 - 4 * c)];
      a2 = t[4'(13 - 4 * c)];
      a3 = t[4'(12 - 4 * c)];
      m[4'(15 - 4 * c)] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      m[4'(14 - 4 * c)] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      m[4'(13 - 4 * c)] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      m[4'(12 - 4 * c)] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    if (last) begin
      return t ^ rk;
    end else begin
      return m ^ rk;
    end
  endfunction

  state_t       r_fsm;
  logic [127:0] r_state;
  logic [127:0] r_key;
  logic [3:0]   r_cnt;
  logic [127:0] r_out_data;
  logic         r_out_valid;

  logic [127:0] w_next_state;
  logic [127:0] w_next_key;
  logic [3:0]   w_rnd;
  logic [3:0]   w_cnt_next;

  assign w_cnt_next = r_cnt + C_STEP;

  // Unrolled round chain: key and data advance together, one round per stage.
  always_comb begin
    w_next_state = r_state;
    w_next_key   = r_key;
    w_rnd        = r_cnt;
    for (int g = 0; g < ROUNDS_PER_CYCLE; g++) begin
      w_rnd        = r_cnt + 4'(g + 1);
      w_next_key   = key_step(w_next_key, rcon(w_rnd));
      w_next_state = aes_round(w_next_state, w_next_key, (w_rnd == C_LAST));
    end
  end

  // Control FSM plus the state, key, counter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm       <= S_IDLE;
      r_state     <= 128'h0;
      r_key       <= 128'h0;
      r_cnt       <= 4'd0;
      r_out_data  <= 128'h0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          // in_ready is high whenever IDLE is reached out of reset.
          if (in_valid) begin
            r_state <= in_data ^ in_key;
            r_key   <= in_key;
            r_cnt   <= 4'd0;
            r_fsm   <= S_RUN;
          end
        end
        S_RUN: begin
          r_state <= w_next_state;
          r_key   <= w_next_key;
          if (w_cnt_next == C_LAST) begin
            r_out_data  <= w_next_state;
            r_out_valid <= 1'b1;
            r_cnt       <= 4'd0;
            r_fsm       <= S_DONE;
          end else begin
            r_cnt <= w_cnt_next;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_fsm       <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_fsm       <= S_IDLE;
        end
      endcase
    end
  end

  // Handshake status is decoded purely from the registered state.
  assign in_ready  = (r_fsm == S_IDLE) & ~rst;
  assign busy      = (r_fsm != S_IDLE);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_aes128_iter_core.sv
// Self-checking bench for aes128_iter_core: four instances (R=1,2,5,10),
// a behavioural AES reference built from GF(2^8) arithmetic, and a
// per-cycle protocol model compared against every instance.
module tb_aes128_iter_core;

  logic         clk;
  logic         rst;
  logic         in_valid_a  [4];
  logic         in_ready_a  [4];
  logic [127:0] in_data_a   [4];
  logic [127:0] in_key_a    [4];
  logic         out_valid_a [4];
  logic         out_ready_a [4];
  logic [127:0] out_data_a  [4];
  logic         busy_a      [4];

  int n_checks = 0;
  int n_errors = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int R = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 5 : 10;
    aes128_iter_core #(.ROUNDS_PER_CYCLE(R)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid_a[g]),
      .in_ready  (in_ready_a[g]),
      .in_data   (in_data_a[g]),
      .in_key    (in_key_a[g]),
      .out_valid (out_valid_a[g]),
      .out_ready (out_ready_a[g]),
      .out_data  (out_data_a[g]),
      .busy      (busy_a[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference AES ----------------
  logic [7:0] sb [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int n = 0; n < 8; n++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0]  w [44];
    logic [7:0]   st [4][4];
    logic [7:0]   tmp [4][4];
    logic [7:0]   base [4];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [127:0] res;
    base[0] = 8'h02; base[1] = 8'h03; base[2] = 8'h01; base[3] = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = 32'(key >> (32 * (3 - i)));
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        st[r][c] = 8'(pt >> (8 * (15 - (r + 4 * c)))) ^ 8'(w[c] >> (8 * (3 - r)));
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          tmp[r][c] = sb[st[r][(c + r) % 4]];
      st = tmp;
      if (rnd < 10) begin
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++) begin
            tmp[r][c] = 8'h00;
            for (int j = 0; j < 4; j++) tmp[r][c] = tmp[r][c] ^ gmul(base[(j - r + 4) % 4], st[j][c]);
          end
        st = tmp;
      end
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          st[r][c] = st[r][c] ^ 8'(w[4 * rnd + c] >> (8 * (3 - r)));
    end
    res = 128'h0;
    for (int k = 0; k < 16; k++) res = {res[119:0], st[k % 4][k / 4]};
    return res;
  endfunction

  function automatic int ncyc_of(input int i);
    return (i == 0) ? 10 : (i == 1) ? 5 : (i == 2) ? 2 : 1;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- protocol model ----------------
  int           m_phase [4];   // 0 waiting for a block, 1 computing, 2 holding result
  int           m_cnt   [4];
  logic [127:0] m_pend  [4];
  logic [127:0] m_out   [4];
  logic         m_valid [4];

  // Model: accept in idle, result appears NCYC edges later, held until out_ready.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_phase[i] <= 0; m_cnt[i] <= 0; m_out[i] <= 128'h0; m_valid[i] <= 1'b0; m_pend[i] <= 128'h0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        case (m_phase[i])
          0: if (in_valid_a[i]) begin
               m_pend[i]  <= aes_ref(in_data_a[i], in_key_a[i]);
               m_cnt[i]   <= ncyc_of(i);
               m_phase[i] <= 1;
             end
          1: if (m_cnt[i] == 1) begin
               m_out[i] <= m_pend[i]; m_valid[i] <= 1'b1; m_phase[i] <= 2;
             end else begin
               m_cnt[i] <= m_cnt[i] - 1;
             end
          2: if (out_ready_a[i]) begin
               m_valid[i] <= 1'b0; m_phase[i] <= 0;
             end
          default: m_phase[i] <= 0;
        endcase
      end
    end
  end

  // Compare every instance against the model on each falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("inst%0d in_ready", i), 128'(in_ready_a[i]), 128'((m_phase[i] == 0) && !rst));
      chk($sformatf("inst%0d busy", i), 128'(busy_a[i]), 128'(m_phase[i] != 0));
      chk($sformatf("inst%0d out_valid", i), 128'(out_valid_a[i]), 128'(m_valid[i]));
      chk($sformatf("inst%0d out_data", i), out_data_a[i], m_out[i]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_block(input int i, input logic [127:0] pt, input logic [127:0] key,
                           input logic [127:0] exp, input int lat, input string nm,
                           input bit scramble, input bit hs);
    int k;
    @(negedge clk);
    chk({nm, " in_ready before accept"}, 128'(in_ready_a[i]), 128'(1));
    in_data_a[i] = pt; in_key_a[i] = key; in_valid_a[i] = 1'b1; out_ready_a[i] = hs;
    @(negedge clk);
    in_valid_a[i] = 1'b0;
    k = 0;
    while (!out_valid_a[i] && k < 40) begin
      if (scramble) begin
        in_data_a[i] = rnd128(); in_key_a[i] = rnd128(); in_valid_a[i] = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      k++;
    end
    in_valid_a[i] = 1'b0;
    chk({nm, " latency"}, 128'(k), 128'(lat));
    chk({nm, " out_data"}, out_data_a[i], exp);
    if (hs) begin
      @(negedge clk);
      chk({nm, " in_ready after handshake"}, 128'(in_ready_a[i]), 128'(1));
      chk({nm, " out_valid after handshake"}, 128'(out_valid_a[i]), 128'(0));
    end
  endtask

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] pt, key;
    logic [127:0] s_pt [3];
    logic [127:0] s_key [3];
    logic [127:0] s_ct [3];
    logic [127:0] got [3];
    int acc_t [3];
    int na, no, i;
    bit acc;

    rst = 1'b1;
    for (int j = 0; j < 4; j++) begin
      in_valid_a[j] = 1'b0; in_data_a[j] = 128'h0; in_key_a[j] = 128'h0; out_ready_a[j] = 1'b0;
    end
    build_sbox();

    // Pin the reference model to the published vectors.
    chk("ref C.1", aes_ref(C1_PT, C1_KEY), C1_CT);
    chk("ref App.B", aes_ref(B_PT, B_KEY), B_CT);
    chk("ref zero", aes_ref(128'h0, 128'h0), Z_CT);

    // Reset state.
    repeat (2) @(negedge clk);
    chk("reset in_ready", 128'(in_ready_a[0]), 128'(0));
    chk("reset out_valid", 128'(out_valid_a[0]), 128'(0));
    chk("reset busy", 128'(busy_a[0]), 128'(0));
    chk("reset out_data", out_data_a[0], 128'h0);
    @(posedge clk); #2 rst = 1'b0;

    run_block(0, C1_PT, C1_KEY, C1_CT, 10, "C.1 R=1", 1'b0, 1'b1);
    for (int j = 0; j < 4; j++)
      run_block(j, B_PT, B_KEY, B_CT, ncyc_of(j), $sformatf("App.B inst%0d", j), 1'b0, 1'b1);

    // Backpressure: hold out_ready low for 20 cycles, then pulse it.
    run_block(0, 128'h0, 128'h0, Z_CT, 10, "zero R=1", 1'b0, 1'b0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("hold out_valid", 128'(out_valid_a[0]), 128'(1));
      chk("hold out_data", out_data_a[0], Z_CT);
      chk("hold in_ready", 128'(in_ready_a[0]), 128'(0));
    end
    out_ready_a[0] = 1'b1;
    @(negedge clk);
    out_ready_a[0] = 1'b0;
    chk("release in_ready", 128'(in_ready_a[0]), 128'(1));
    chk("release out_valid", 128'(out_valid_a[0]), 128'(0));
    chk("release out_data kept", out_data_a[0], Z_CT);

    // Random blocks with input scrambling while the core is computing.
    for (int n = 0; n < 8; n++) begin
      i = $urandom_range(0, 3);
      pt = rnd128(); key = rnd128();
      run_block(i, pt, key, aes_ref(pt, key), ncyc_of(i), $sformatf("random%0d inst%0d", n, i), 1'b1, 1'b1);
    end

    // Reset four cycles into a block, then a clean block.
    @(negedge clk);
    in_data_a[0] = rnd128(); in_key_a[0] = rnd128(); in_valid_a[0] = 1'b1; out_ready_a[0] = 1'b1;
    @(negedge clk);
    in_valid_a[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("busy before abort", 128'(busy_a[0]), 128'(1));
    #1 rst = 1'b1;
    #1;
    chk("abort out_valid", 128'(out_valid_a[0]), 128'(0));
    chk("abort out_data", out_data_a[0], 128'h0);
    chk("abort busy", 128'(busy_a[0]), 128'(0));
    chk("abort in_ready", 128'(in_ready_a[0]), 128'(0));
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    chk("post-abort in_ready", 128'(in_ready_a[0]), 128'(1));
    run_block(0, C1_PT, C1_KEY, C1_CT, 10, "C.1 after abort", 1'b0, 1'b1);

    // Back-to-back stream on R=2 with in_valid and out_ready held high.
    s_pt[0] = C1_PT;  s_key[0] = C1_KEY; s_ct[0] = C1_CT;
    s_pt[1] = B_PT;   s_key[1] = B_KEY;  s_ct[1] = B_CT;
    s_pt[2] = 128'h0; s_key[2] = 128'h0; s_ct[2] = Z_CT;
    out_ready_a[1] = 1'b1;
    @(negedge clk);
    in_data_a[1] = s_pt[0]; in_key_a[1] = s_key[0]; in_valid_a[1] = 1'b1;
    na = 0; no = 0;
    for (int c = 0; c < 120 && no < 3; c++) begin
      acc = in_valid_a[1] && in_ready_a[1];
      if (acc && na < 3) begin acc_t[na] = c; na++; end
      if (out_valid_a[1] && no < 3) begin got[no] = out_data_a[1]; no++; end
      @(negedge clk);
      if (acc) begin
        if (na < 3) begin
          in_data_a[1] = s_pt[na]; in_key_a[1] = s_key[na];
        end else begin
          in_valid_a[1] = 1'b0;
        end
      end
    end
    in_valid_a[1] = 1'b0;
    chk("stream accepts", 128'(na), 128'(3));
    chk("stream results", 128'(no), 128'(3));
    for (int j = 0; j < 3; j++) chk($sformatf("stream out%0d", j), got[j], s_ct[j]);
    chk("stream spacing 0-1", 128'(acc_t[1] - acc_t[0]), 128'(7));
    chk("stream spacing 1-2", 128'(acc_t[2] - acc_t[1]), 128'(7));

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/aes128_iter_core.md
Name: aes128_iter_core

Overview:
Sequential AES-128 encryption core with valid/ready handshakes, running FIPS-197 rounds over multiple clock cycles. It is the clocked, parametrised successor to the team's combinational AES128 block. Throughput and area trade off through an unroll factor. The round key is expanded on the fly, so no key schedule is stored. The block sits between a plaintext/key producer and a ciphertext consumer, one block in flight at a time.

Parameters:
ROUNDS_PER_CYCLE, 1, AES rounds evaluated per clock; legal values 1, 2, 5, 10; any other value is a elaboration error.
NCYC (localparam), 10/ROUNDS_PER_CYCLE, compute cycles per block.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  producer offers in_data/in_key
in_ready  output  1  core can accept a block
in_data  input  128  plaintext; byte 0 = bits [127:120], column-major state per FIPS-197
in_key  input  128  cipher key, same byte order
out_valid  output  1  out_data holds a finished ciphertext
out_ready  input  1  consumer accepts out_data
out_data  output  128  ciphertext, same byte order
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (async, rst=1): state=IDLE; out_valid=0; out_data=0; busy=0; in_ready=0 while rst is high; internal state, round key and round counter cleared. Reset mid-RUN or mid-DONE aborts the block, and it is never emitted.
- FSM: IDLE -> RUN -> DONE -> IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready at edge t:
  - state register <= in_data ^ in_key
  - key register <= in_key
  - round counter <= 0
  - go to RUN
  - in_data/in_key are not sampled again.
- RUN: in_ready=0. Each edge applies ROUNDS_PER_CYCLE consecutive rounds r = cnt+1 .. cnt+ROUNDS_PER_CYCLE, then cnt += ROUNDS_PER_CYCLE.
  - Rounds 1-9: SubBytes, ShiftRows, MixColumns, AddRoundKey(K_r).
  - Round 10: MixColumns is omitted.
  - K_r derives from K_(r-1) within the same combinational chain: RotWord, SubWord, xor Rcon[r], with Rcon = 01,02,04,08,10,20,40,80,1b,36.
  - On the edge where the round-10 result is formed: out_data <= result, out_valid <= 1, go to DONE.
- Latency: out_valid rises exactly NCYC edges after the accept edge t (edge t+NCYC). Concretely: R=1 -> 10, R=2 -> 5, R=5 -> 2, R=10 -> 1.
- DONE: out_valid=1, out_data stable, in_ready=0.
  - On out_valid&&out_ready: out_valid <= 0, go to IDLE.
  - in_ready returns 1 on the following cycle; there is no same-cycle accept in DONE.
  - out_data keeps its last value after the handshake and is not cleared.
- Backpressure: out_ready low holds DONE indefinitely. out_ready is ignored outside DONE.
- in_valid is ignored outside IDLE. Changing in_data/in_key during RUN has no effect on the result.
- Minimum block period: NCYC+2 cycles with out_ready tied high.
- in_ready and busy are decoded from registered state, with no combinational path from in_valid or out_ready.
- S-box: the team's existing combinational byte S-box, one instance per byte per unrolled round plus 4 per key step. GF(2^8) xtime uses polynomial 0x11b.

Test Plan:
- FIPS-197 C.1, R=1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a; out_valid rises exactly 10 edges after accept.
- FIPS-197 App. B, repeated for R=1,2,5,10: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32; latency 10/5/2/1 respectively.
- All-zero key and pt -> 66e94bd4ef8a2c3b884cfa59ca342b2e. Hold out_ready=0 for 20 cycles -> out_valid stays 1, out_data stable, in_ready=0 throughout. Then pulse out_ready -> in_ready=1 on the next cycle.
- Randomise in_data/in_key and toggle in_valid during RUN -> result still equals the vector accepted at edge t.
- Assert rst 4 cycles into RUN -> out_valid/out_data/busy go 0 immediately (asynchronous). After release, in_ready=1 and the next block (C.1 vector) completes correctly, with no residue of the aborted block.
- Back-to-back stream of 3 vectors with in_valid held high and out_ready high, R=2 -> all three correct, in order, accepts spaced exactly 7 cycles apart.
